cla_nibble_serial_adder: RTL
============================

Name: cla_nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around a single CLA_4bit_Adder instance.
- It is the sequencing stage that feeds that slice one nibble per cycle and collects its sum and carry-out.
- A registered carry chains each nibble into the next.
- Trades latency (WIDTH/4 cycles) for area.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of 4 and at least 4; any other value is a configuration error.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: operands a, b and cin are valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in to nibble 0.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: a + b + cin, modulo 2^WIDTH.
- cout, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: two's-complement overflow.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Nibble index=0, carry register=0, operand registers=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge: latch a, b; carry register<=cin; index<=0; sum register<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the CLA slice sees a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register.
  - At the edge: sum[4i+3:4i]<=slice sum; carry register<=slice cout; index<=i+1.
  - When i==WIDTH/4-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1, and sum, cout, ovf are registered and stable.
  - cout = final carry register.
  - ovf = (a_reg[MSB]==b_reg[MSB]) & (sum[MSB]!=a_reg[MSB]).
  - Outputs hold indefinitely while out_ready=0.
  - On out_valid&out_ready at an edge: go to IDLE. out_valid drops and in_ready rises in the next cycle.
- Latency:
  - Accept edge is T.
  - out_valid is high in the cycle after edge T+WIDTH/4; that is, exactly WIDTH/4 RUN cycles.
  - Minimum issue interval is WIDTH/4+2 cycles. There is no overlap of consecutive operations.
- Outputs are registered only; there is no combinational path from in_* to out_*.
- sum, cout and ovf are don't-care-stable outside DONE. They hold their last values and are only meaningful while out_valid=1.
- in_valid asserted during RUN or DONE is ignored; it is not captured. The producer must hold it until in_ready.
- a and b changing after the accept edge has no effect.
- WIDTH=4 degenerate case: one RUN cycle.
- Asynchronous reset mid-RUN or mid-DONE aborts the operation. The partial result is discarded and no out_valid pulse is produced.
- Reset deassertion is synchronised externally; the block assumes a clean release.
- Carry register chains strictly in nibble order 0 to WIDTH/4-1; no speculative carry.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> after 4 RUN cycles: out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0. Check out_valid rises exactly 4 cycles after the accept edge, and in_ready=0 throughout RUN/DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/cout/ovf/out_valid unchanged. Pulse in_valid with new operands during that window -> ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN after 2 nibbles of 0xABCD+0x1111 -> immediately in_ready=1, out_valid=0, sum=0. Then a new 0x0001+0x0001 completes with sum=0x0002.
- Randomised back-to-back: 1000 random a/b/cin with random out_ready stalls -> every result equals the reference a+b+cin. Exactly one output per accepted input, in order.

Source files
------------

// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused once per
// nibble, with a registered carry chaining the nibbles and valid/ready handshakes on both sides.

module CLA_4bit_Adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Each carry is expanded from generate/propagate terms so no carry ripples through the slice.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_widthCheck
            $error("cla_nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDX_W-1:0] r_idx;

    logic [3:0] w_aNib;
    logic [3:0] w_bNib;
    logic [3:0] w_sliceSum;
    logic       w_sliceCout;
    logic       w_lastNib;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastNib) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_lastNib = (r_idx == LAST_IDX);

    // Select the current nibble of each latched operand for the shared slice.
    always_comb begin
        w_aNib = 4'h0;
        w_bNib = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_aNib = r_a[n*4 +: 4];
                w_bNib = r_b[n*4 +: 4];
            end
        end
    end

    CLA_4bit_Adder u_slice (
        .i_a    (w_aNib),
        .i_b    (w_bNib),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    // Datapath: capture operands on accept, fill one sum nibble per RUN cycle, and
    // register carry-out and overflow alongside the final nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IDX_W'(n)) begin
                            r_sum[n*4 +: 4] <= w_sliceSum;
                        end
                    end
                    r_carry <= w_sliceCout;
                    if (w_lastNib) begin
                        r_cout <= w_sliceCout;
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                                  (w_sliceSum[3] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
